// File: rtl/lane_split_pkg.sv
// lane_split_pkg: shared types and limits for the lane_split_rx receiver.
//   ls_state_e   - receiver FSM state encoding
//   LS_WIDTH_DEF - default lane word width
//   LS_WIDTH_MAX - widest supported lane word
package lane_split_pkg;

   localparam int LS_WIDTH_DEF = 8;
   localparam int LS_WIDTH_MAX = 32;

   typedef enum logic [1:0] {
      FILL_A = 2'd0,
      PAR_A  = 2'd1,
      FILL_B = 2'd2,
      PAR_B  = 2'd3
   } ls_state_e;

endpackage

// File: rtl/lane_bit_collect.sv
// lane_bit_collect: MSB-first bit shifter and word counter for lane_split_rx.
// Build option: LANE_SPLIT_RX_PARITY_EN adds a running parity accumulator.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   bit_in      - serial bit being accepted
//   shift_en    - accept bit_in into the current word
//   word        - the word as it stands including bit_in (complete when word_done)
//   word_done   - bit_in is the last bit of a word
//   word_par    - (parity build) XOR of all word bits including bit_in
//   last_bit    - (default build) next accepted bit completes a word
module lane_bit_collect
   import lane_split_pkg::*;
#(
   parameter int WIDTH = LS_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             bit_in,
   input  logic             shift_en,
   output logic [WIDTH-1:0] word,
   output logic             word_done,
`ifdef LANE_SPLIT_RX_PARITY_EN
   output logic             word_par
`else
   output logic             last_bit
`endif
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   // Only WIDTH-1 bits need storing: the final bit completes the word
   // combinationally and is consumed on the same edge.
   logic [WIDTH-2:0] sr_q, sr_d;
   logic [CW-1:0]    bitcnt_q, bitcnt_d;
   logic             at_last;

   assign at_last   = (bitcnt_q == LAST_CNT);
   assign word      = {sr_q, bit_in};
   assign word_done = shift_en && at_last;

   always_comb begin
      sr_d     = sr_q;
      bitcnt_d = bitcnt_q;
      if (shift_en) begin
         sr_d     = word[WIDTH-2:0];
         bitcnt_d = at_last ? '0 : bitcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_q     <= '0;
         bitcnt_q <= '0;
      end else begin
         sr_q     <= sr_d;
         bitcnt_q <= bitcnt_d;
      end
   end

`ifdef LANE_SPLIT_RX_PARITY_EN
   logic par_q, par_d;

   assign word_par = par_q ^ bit_in;

   always_comb begin
      par_d = par_q;
      if (shift_en) par_d = at_last ? 1'b0 : word_par;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_q <= 1'b0;
      else        par_q <= par_d;
   end
`else
   assign last_bit = at_last;
`endif

endmodule

// File: rtl/lane_split_rx.sv
// lane_split_rx: serial bit stream to paired lane words (mid1 = first, mid2 = second).
// Build option: LANE_SPLIT_RX_PARITY_EN - each word followed by an even-parity
//   bit; a mismatch sets the sticky err flag (word still delivered).
// Ports:
//   clk, rst_n           - clock, async active-low reset
//   in_bit/in_valid/in_ready - serial input handshake, MSB first
//   mid1, mid2           - registered word pair
//   mid_valid/mid_ready  - output pair handshake
//   err                  - sticky parity error (0 in default build)
//
// state  | meaning
// FILL_A | collecting the first word of a pair
// PAR_A  | waiting for the parity bit of the first word
// FILL_B | collecting the second word of a pair
// PAR_B  | waiting for the parity bit of the second word; loads the pair
module lane_split_rx
   import lane_split_pkg::*;
#(
   parameter int WIDTH = LS_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_bit,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] mid1,
   output logic [WIDTH-1:0] mid2,
   output logic             mid_valid,
   input  logic             mid_ready,
   output logic             err
);

   ls_state_e        state_q, state_d;
   logic [WIDTH-1:0] a_hold_q, a_hold_d;
   logic [WIDTH-1:0] mid1_q, mid1_d;
   logic [WIDTH-1:0] mid2_q, mid2_d;
   logic             mid_valid_q, mid_valid_d;

   logic [WIDTH-1:0] word;
   logic             word_done;
   logic             pair_last;
   logic             accept;
   logic             shift_en;

`ifdef LANE_SPLIT_RX_PARITY_EN
   logic [WIDTH-1:0] b_hold_q, b_hold_d;
   logic             par_exp_q, par_exp_d;
   logic             err_q, err_d;
   logic             word_par;

   assign pair_last = (state_q == PAR_B);
`else
   logic             last_bit;

   assign pair_last = (state_q == FILL_B) && last_bit;
`endif

   // Stall only the bit that would overwrite a pair nobody has taken yet.
   assign in_ready = !(pair_last && mid_valid_q && !mid_ready);
   assign accept   = in_valid && in_ready;
   assign shift_en = accept && ((state_q == FILL_A) || (state_q == FILL_B));

   lane_bit_collect #(.WIDTH(WIDTH)) u_collect (
      .clk       (clk),
      .rst_n     (rst_n),
      .bit_in    (in_bit),
      .shift_en  (shift_en),
      .word      (word),
      .word_done (word_done),
`ifdef LANE_SPLIT_RX_PARITY_EN
      .word_par  (word_par)
`else
      .last_bit  (last_bit)
`endif
   );

   always_comb begin
      state_d     = state_q;
      a_hold_d    = a_hold_q;
      mid1_d      = mid1_q;
      mid2_d      = mid2_q;
      mid_valid_d = mid_valid_q && !mid_ready;
`ifdef LANE_SPLIT_RX_PARITY_EN
      b_hold_d    = b_hold_q;
      par_exp_d   = par_exp_q;
      err_d       = err_q;
`endif
      case (state_q)
         FILL_A: begin
            if (word_done) begin
               a_hold_d = word;
`ifdef LANE_SPLIT_RX_PARITY_EN
               par_exp_d = word_par;
               state_d   = PAR_A;
`else
               state_d   = FILL_B;
`endif
            end
         end
         FILL_B: begin
            if (word_done) begin
`ifdef LANE_SPLIT_RX_PARITY_EN
               b_hold_d  = word;
               par_exp_d = word_par;
               state_d   = PAR_B;
`else
               mid1_d      = a_hold_q;
               mid2_d      = word;
               mid_valid_d = 1'b1;
               state_d     = FILL_A;
`endif
            end
         end
`ifdef LANE_SPLIT_RX_PARITY_EN
         PAR_A: begin
            if (accept) begin
               if (in_bit != par_exp_q) err_d = 1'b1;
               state_d = FILL_B;
            end
         end
         PAR_B: begin
            if (accept) begin
               if (in_bit != par_exp_q) err_d = 1'b1;
               mid1_d      = a_hold_q;
               mid2_d      = b_hold_q;
               mid_valid_d = 1'b1;
               state_d     = FILL_A;
            end
         end
`endif
         default: state_d = FILL_A;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= FILL_A;
         a_hold_q    <= '0;
         mid1_q      <= '0;
         mid2_q      <= '0;
         mid_valid_q <= 1'b0;
`ifdef LANE_SPLIT_RX_PARITY_EN
         b_hold_q    <= '0;
         par_exp_q   <= 1'b0;
         err_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_hold_q    <= a_hold_d;
         mid1_q      <= mid1_d;
         mid2_q      <= mid2_d;
         mid_valid_q <= mid_valid_d;
`ifdef LANE_SPLIT_RX_PARITY_EN
         b_hold_q    <= b_hold_d;
         par_exp_q   <= par_exp_d;
         err_q       <= err_d;
`endif
      end
   end

   assign mid1      = mid1_q;
   assign mid2      = mid2_q;
   assign mid_valid = mid_valid_q;
`ifdef LANE_SPLIT_RX_PARITY_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule
